spi_rx_fifo: RTL and testbench

Byte buffer directly downstream of the SPI slave receive path. Bytes assembled from MOSI, already transferred into the system clock domain, are pushed here one per cycle. Core logic drains them at its own pace through a first-word-fall-through valid/ready port. Overruns are recorded in a sticky flag so the host protocol can detect lost bytes.

---
 rtl/spi_rx_fifo.sv | 118 +++++++++++
 tb/tb_spi_rx_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_fifo
// Description : First-word-fall-through byte FIFO sitting behind the SPI
//               slave receive path. Accepts one byte per cycle, drains
//               through a valid/ready port, and records dropped pushes in a
//               sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Handshake decode: only registered state gates the push, so a pop while
    // full frees the slot the incoming byte takes in the same cycle.
    always_comb begin
        w_pop  = valid_q & rd_ready;
        w_push = wr_en & (~full_q | w_pop);
        w_drop = wr_en & full_q & ~w_pop;
    end

    // Next-state for pointers, occupancy, derived flags and sticky overflow.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (w_push) begin
            wp_d = wp_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rp_d = rp_q + C_PTR_ONE;
        end

        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_ONE;
        end else if (w_pop && !w_push) begin
            count_d = count_q - C_CNT_ONE;
        end

        // A drop in the same cycle as a clear must still be reported.
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        full_d  = (count_d == C_DEPTH);
        valid_d = (count_d != '0);
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage array is not reset; writes are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            mem[wp_q] <= wr_data;
        end
    end

    assign rd_data  = mem[rp_q];
    assign rd_valid = valid_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_rx_fifo
// Description : Self-checking bench for spi_rx_fifo; directed scenarios plus
//               a randomized phase, all checked against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic             full;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [5:0]       count;
    logic             overflow;
    logic             clr_ovf;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of stored bytes and a sticky drop flag.
    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;

    spi_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare every DUT output against the model state.
    task automatic check_all(input string tag);
        chk(32'(count), 32'(m_q.size()), {tag, " count"});
        chk(32'(full), 32'(m_q.size() == DEPTH), {tag, " full"});
        chk(32'(rd_valid), 32'(m_q.size() != 0), {tag, " rd_valid"});
        chk(32'(overflow), 32'(m_ovf), {tag, " overflow"});
        if (m_q.size() != 0) begin
            chk(32'(rd_data), 32'(m_q[0]), {tag, " rd_data"});
        end
    endtask

    // Apply one cycle of inputs, advance the model by the FIFO rules, check.
    task automatic step(input logic we, input logic [7:0] d, input logic rr,
                        input logic co, input logic rn, input string tag);
        logic pop;
        logic drop;
        logic push;
        wr_en    = we;
        wr_data  = d;
        rd_ready = rr;
        clr_ovf  = co;
        rst_n    = rn;
        @(posedge clk);
        if (!rn) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = (m_q.size() != 0) && rr;
            drop = we && (m_q.size() == DEPTH) && !pop;
            push = we && !drop;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(d);
            if (drop) m_ovf = 1'b1;
            else if (co) m_ovf = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0; clr_ovf = 1'b0;

        // Reset held two cycles with pushes requested.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "reset0");
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, "reset1");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "post_reset");
        chk(32'(count), 32'd0, "reset count zero");

        // Fill then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, "fill");
        chk(32'(full), 32'd1, "fill full");
        chk(32'(count), 32'd32, "fill count");
        for (int i = 0; i < DEPTH; i++) begin
            chk(32'(rd_data), 32'(i), "drain order");
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "drain");
        end
        chk(32'(rd_valid), 32'd0, "drain empty");

        // Refill, then overflow behaviour.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, "refill");
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, "drop");
        chk(32'(overflow), 32'd1, "drop overflow");
        chk(32'(count), 32'd32, "drop count");
        step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, "drop_and_clr");
        chk(32'(overflow), 32'd1, "set wins over clear");
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "clr");
        chk(32'(overflow), 32'd0, "clear overflow");

        // Push while popping at full.
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, "full_pop");
        chk(32'(count), 32'd32, "full_pop count");
        chk(32'(full), 32'd1, "full_pop full");
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk(32'(rd_data), 32'h55, "full_pop last");
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "drain2");
        end

        // Wrap-around stream with an alternating consumer.
        begin
            int n = 0;
            int guard = 0;
            logic rr = 1'b1;
            while ((n < 100 || m_q.size() != 0) && guard < 1000) begin
                logic we;
                we = (n < 100) && (m_q.size() < DEPTH);
                step(we, 8'(n), rr, 1'b0, 1'b1, "wrap");
                if (we) n++;
                rr = ~rr;
                guard++;
            end
            chk(32'(guard < 1000), 32'd1, "wrap bounded");
            chk(32'(overflow), 32'd0, "wrap no overflow");
        end

        // Reset in the middle of operation.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b1, "pre_rst");
        chk(32'(count), 32'd5, "pre_rst count");
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, "mid_rst");
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, "post_rst_push");
        chk(32'(rd_data), 32'h42, "post_rst data");
        chk(32'(rd_valid), 32'd1, "post_rst valid");
        chk(32'(count), 32'd1, "post_rst count");

        // Randomized traffic, including occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            logic we;
            logic rr;
            logic co;
            logic rn;
            we = ($urandom_range(0, 99) < 60);
            rr = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
            co = ($urandom_range(0, 15) == 0);
            rn = ($urandom_range(0, 199) != 0);
            step(we, 8'($urandom), rr, co, rn, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
